lh_ootx_frame_decoder: RTL and testbench



---
 rtl/lh_ootx_frame_decoder.sv | 118 +++++++++++
 tb/tb_lh_ootx_frame_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lh_ootx_frame_decoder.sv
// lh_ootx_frame_decoder: OOTX frame decoder (preamble, length, sync, payload writes); CRC-32 check when LH_OOTX_CRC_EN is defined
module lh_ootx_frame_decoder #(
  parameter int MAX_BYTES = 64,
  parameter int ADDR_W = 8,
  parameter int PREAMBLE_ZEROS = 17,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              DATA_IN,
  input  logic              DCLK,
  output logic [15:0]       DATA_OUT,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic              WR_EN,
  output logic [15:0]       LENGTH,
  output logic              READY,
  output logic              CRC_OK,
  output logic              ERROR
);
  localparam logic [2:0] HUNT = 3'd0, LEN = 3'd1, PAY = 3'd2, CRC = 3'd3, DONE = 3'd4;
  localparam int ZW = $clog2(PREAMBLE_ZEROS + 1);
  localparam logic [ZW-1:0] ZMAX = ZW'(PREAMBLE_ZEROS);
  logic [SYNC_STAGES-1:0] dclk_s, data_s;
  logic dclk_d, bit_v, bit_d;
  logic [2:0] state;
  logic [ZW-1:0] zc;
  logic [4:0] cnt;
  logic [15:0] sr, wc, word, nwords;
  logic preamble, start, last_word;
  assign word = {sr[14:0], bit_d};
  assign preamble = !bit_d && zc == ZMAX - ZW'(1);
  assign start = state == HUNT && bit_d && zc == ZMAX;
  assign nwords = 16'((17'(LENGTH) + 17'd1) >> 1);
  assign last_word = wc == nwords - 16'd1;
  always_ff @(posedge CLK)
    if (!RESET_N) begin
      dclk_s <= '0;
      data_s <= '0;
      dclk_d <= 1'b0;
      bit_v <= 1'b0;
      bit_d <= 1'b0;
      state <= HUNT;
      zc <= '0;
      cnt <= '0;
      sr <= '0;
      wc <= '0;
      DATA_OUT <= '0;
      ADDRESS <= '0;
      WR_EN <= 1'b0;
      LENGTH <= '0;
      READY <= 1'b0;
      ERROR <= 1'b0;
    end else begin
      dclk_s <= {dclk_s[SYNC_STAGES-2:0], DCLK};
      data_s <= {data_s[SYNC_STAGES-2:0], DATA_IN};
      dclk_d <= dclk_s[SYNC_STAGES-1];
      bit_v <= dclk_s[SYNC_STAGES-1] && !dclk_d;
      bit_d <= data_s[SYNC_STAGES-1];
      WR_EN <= 1'b0;
      READY <= state == DONE;
      ERROR <= 1'b0;
      if (state == DONE) state <= HUNT;
      if (bit_v) begin
        zc <= bit_d ? '0 : zc == ZMAX ? zc : zc + ZW'(1);
        cnt <= cnt == 5'd16 ? '0 : cnt + 5'd1;
        sr <= word;
        if (preamble) state <= HUNT;
        else if (start) begin
          state <= LEN;
          cnt <= '0;
          wc <= '0;
        end else if (state != HUNT && cnt == 5'd16) begin
          if (!bit_d) begin
            ERROR <= 1'b1;
            state <= HUNT;
            zc <= ZW'(1);
          end else if (state == LEN) begin
            LENGTH <= sr;
            ERROR <= sr > 16'(MAX_BYTES);
            state <= sr > 16'(MAX_BYTES) ? HUNT : sr == 16'd0 ? CRC : PAY;
          end else begin
            state <= state == PAY ? (last_word ? CRC : PAY) : wc == 16'd1 ? DONE : CRC;
            wc <= (state == PAY && !last_word) || (state == CRC && wc == 16'd0) ? wc + 16'd1 : 16'd0;
          end
        end else if (state == PAY && cnt == 5'd15) begin
          WR_EN <= 1'b1;
          DATA_OUT <= word;
          ADDRESS <= wc[ADDR_W-1:0];
        end
      end
    end
`ifdef LH_OOTX_CRC_EN
  logic [31:0] crc, rx;
  logic pad;
  assign pad = LENGTH[0] && last_word;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction
  always_ff @(posedge CLK)
    if (!RESET_N) begin
      crc <= '1;
      rx <= '0;
      CRC_OK <= 1'b0;
    end else if (bit_v) begin
      if (start) crc <= '1;
      else if (state == PAY && cnt == 5'd15)
        crc <= pad ? crc_byte(crc, word[15:8]) : crc_byte(crc_byte(crc, word[15:8]), word[7:0]);
      if (state == CRC && cnt == 5'd15) rx <= {rx[15:0], word};
      if (state == CRC && cnt == 5'd16 && bit_d && wc == 16'd1)
        CRC_OK <= rx == ~{crc[7:0], crc[15:8], crc[23:16], crc[31:24]};
    end
`else
  assign CRC_OK = 1'b1;
`endif
endmodule

// File: tb/tb_lh_ootx_frame_decoder.sv
// tb_lh_ootx_frame_decoder: table-driven frame vectors plus abort/reset sequences, write scoreboard
module tb_lh_ootx_frame_decoder;
  logic CLK = 1'b0, RESET_N = 1'b0, DATA_IN = 1'b0, DCLK = 1'b0;
  logic [15:0] DATA_OUT, LENGTH;
  logic [7:0] ADDRESS;
  logic WR_EN, READY, CRC_OK, ERROR;
`ifdef LH_OOTX_CRC_EN
  localparam logic CRC_EN = 1'b1;
`else
  localparam logic CRC_EN = 1'b0;
`endif
  typedef struct {logic [7:0] addr; logic [15:0] data;} wr_t;
  typedef struct {string name; int len; int bad; logic [15:0] cxor; int ready; int err; logic ok;} vec_t;
  wr_t sb[$];
  wr_t e;
  vec_t vecs[9];
  int n_checks = 0, n_fail = 0, ready_cnt = 0, err_cnt = 0, r0, e0;
  logic ok_seen = 1'b0;

  lh_ootx_frame_decoder dut (
    .CLK(CLK), .RESET_N(RESET_N), .DATA_IN(DATA_IN), .DCLK(DCLK),
    .DATA_OUT(DATA_OUT), .ADDRESS(ADDRESS), .WR_EN(WR_EN), .LENGTH(LENGTH),
    .READY(READY), .CRC_OK(CRC_OK), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (READY) begin
      ready_cnt++;
      ok_seen = CRC_OK;
    end
    if (ERROR) err_cnt++;
    if (WR_EN) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wr_unexpected: ADDRESS %0d DATA_OUT 0x%h, no write expected", ADDRESS, DATA_OUT);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(ADDRESS), 32'(e.addr));
        chk("wr_data", 32'(DATA_OUT), 32'(e.data));
      end
    end
  end

  function automatic logic [7:0] pb(input int i);
    return 8'h31 + 8'(i);
  endfunction

  function automatic logic [31:0] crc32(input int len);
    logic [31:0] c;
    logic [7:0] b;
    c = '1;
    for (int i = 0; i < len; i++) begin
      b = pb(i);
      for (int k = 0; k < 8; k++) c = (c[0] ^ b[k]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return ~c;
  endfunction

  task automatic send_bit(input logic b);
    DATA_IN = b;
    @(negedge CLK);
    DCLK = 1'b1;
    repeat (4) @(negedge CLK);
    DCLK = 1'b0;
    repeat (5) @(negedge CLK);
  endtask

  task automatic send_word(input logic [15:0] w, input logic s);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
    send_bit(s);
  endtask

  task automatic send_pre();
    repeat (17) send_bit(1'b0);
    send_bit(1'b1);
  endtask

  task automatic send_payload(input int len, input int upto);
    logic [15:0] w;
    for (int i = 0; i <= upto; i++) begin
      w = {pb(2 * i), (2 * i + 1 < len) ? pb(2 * i + 1) : 8'h00};
      sb.push_back('{8'(i), w});
      send_word(w, 1'b1);
    end
  endtask

  task automatic send_frame(input int len, input int bad, input logic [15:0] cxor, input logic pre);
    logic [31:0] c;
    logic [15:0] w;
    if (pre) send_pre();
    send_word(16'(len), 1'b1);
    if (len > 64) return;
    for (int i = 0; i < (len + 1) / 2; i++) begin
      w = {pb(2 * i), (2 * i + 1 < len) ? pb(2 * i + 1) : 8'h00};
      sb.push_back('{8'(i), w});
      send_word(w, i != bad);
      if (i == bad) return;
    end
    c = crc32(len);
    send_word({c[7:0], c[15:8]}, 1'b1);
    send_word({c[23:16], c[31:24]} ^ cxor, 1'b1);
  endtask

  task automatic check_frame(input string name, input int ready, input int err, input logic ok, input int len);
    repeat (6) @(negedge CLK);
    chk({name, "_ready"}, 32'(ready_cnt - r0), 32'(ready));
    chk({name, "_error"}, 32'(err_cnt - e0), 32'(err));
    chk({name, "_pending_writes"}, 32'(sb.size()), 32'd0);
    chk({name, "_length"}, 32'(LENGTH), 32'(len));
    if (ready != 0) chk({name, "_crc_ok"}, 32'(ok_seen), 32'(ok));
    sb.delete();
  endtask

  task automatic check_reset(input string name);
    chk({name, "_outputs"}, 32'({DATA_OUT, ADDRESS, WR_EN, READY, ERROR}), 32'd0);
    chk({name, "_length"}, 32'(LENGTH), 32'd0);
    chk({name, "_crc_ok"}, 32'(CRC_OK), 32'(!CRC_EN));
  endtask

  initial begin
    vecs = '{
      '{"spec9", 9, -1, 16'h0000, 1, 0, 1'b1},
      '{"badcrc", 9, -1, 16'h0001, 1, 0, !CRC_EN},
      '{"syncerr", 9, 2, 16'h0000, 0, 1, 1'b1},
      '{"after_err", 9, -1, 16'h0000, 1, 0, 1'b1},
      '{"oversize", 65, -1, 16'h0000, 0, 1, 1'b1},
      '{"len0", 0, -1, 16'h0000, 1, 0, 1'b1},
      '{"len1", 1, -1, 16'h0000, 1, 0, 1'b1},
      '{"len2", 2, -1, 16'h0000, 1, 0, 1'b1},
      '{"len64", 64, -1, 16'h0000, 1, 0, 1'b1}
    };
    repeat (3) @(negedge CLK);
    check_reset("reset");
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 9; i++) begin
      r0 = ready_cnt;
      e0 = err_cnt;
      send_frame(vecs[i].len, vecs[i].bad, vecs[i].cxor, 1'b1);
      check_frame(vecs[i].name, vecs[i].ready, vecs[i].err, vecs[i].ok, vecs[i].len);
    end
    r0 = ready_cnt;
    e0 = err_cnt;
    send_pre();
    send_word(16'd9, 1'b1);
    send_payload(9, 1);
    sb.push_back('{8'd2, 16'h0000});
    repeat (17) send_bit(1'b0);
    send_bit(1'b1);
    send_frame(9, -1, 16'h0000, 1'b0);
    check_frame("abort", 1, 0, 1'b1, 9);
    send_pre();
    send_word(16'd9, 1'b1);
    send_payload(9, 1);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    check_reset("midreset");
    RESET_N = 1'b1;
    chk("midreset_pending_writes", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge CLK);
    r0 = ready_cnt;
    e0 = err_cnt;
    send_frame(9, -1, 16'h0000, 1'b1);
    check_frame("post_reset", 1, 0, 1'b1, 9);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
